xor_arbiter: RTL
================

XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, is the operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has operands pending.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same widths and meanings as requester 0, for requester 1.
REQ-008 out_valid  output  1  result available.
REQ-009 out_data  output  WIDTH  result, equal to a XOR b of the served request.
REQ-010 out_id  output  1  index of the requester served.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block shall share one bit-serial XOR unit between the two requesters using an FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE, grant goes to the sole valid requester; if both are valid, grant goes to the requester not served last (round-robin pointer).
REQ-015 reqN_ready shall be combinational and high only in IDLE while reqN_valid is high and N is granted; at most one ready is high per cycle.
REQ-016 On a cycle T with reqN_valid & reqN_ready, the block shall latch a, b and N, update the pointer to N, clear the bit counter and enter SHIFT.
REQ-017 In SHIFT, each cycle shall process one bit, LSB first: result shift register takes a[i]^b[i] and the counter increments; after exactly WIDTH SHIFT cycles (T+1..T+WIDTH) the FSM enters DONE.
REQ-018 In DONE, out_valid shall be high from cycle T+WIDTH+1, with out_data and out_id stable, until the cycle out_valid & out_ready, after which the FSM returns to IDLE.
REQ-019 Total latency shall be WIDTH+1 cycles from acceptance to first out_valid; minimum issue interval is WIDTH+2 cycles (one IDLE cycle between transactions).
REQ-020 Requester valids and operands are ignored outside IDLE; a requester that drops valid before acceptance loses nothing and changes no state.
REQ-021 out_ready is ignored outside DONE; out_ready held high in DONE completes the handshake in the first DONE cycle.
REQ-022 The bit counter shall be ceil(log2(WIDTH+1)) bits and shall not wrap within a transaction.
REQ-023 out_data and out_id shall hold their last value in IDLE and SHIFT; out_valid is low there.

Reset
REQ-024 While rst_n is low, the FSM shall be IDLE, out_valid 0, out_data 0, out_id 0, busy 0, counter 0, and pointer set so requester 0 wins the first contention.
REQ-025 Reset asserted mid-SHIFT or mid-DONE shall abort the transaction immediately with no result delivered; operation resumes on the first rising edge after rst_n goes high.
REQ-026 reqN_ready shall be low throughout reset.

Verification
REQ-027 WIDTH=8; after reset, req0 only, a=8'hA5, b=8'h0F, out_ready=1 -> req0_ready high at T, out_valid at T+9 with out_data=8'hAA, out_id=0, busy low at T+10.
REQ-028 Both valid continuously after reset, out_ready=1 -> grants alternate 0,1,0,1; each result returns with the correct out_id; accepts are 10 cycles apart.
REQ-029 Result with out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_id stable all 5 cycles; no ready to either requester until handshake plus one cycle.
REQ-030 req1 valid asserted during req0's SHIFT -> req1_ready stays low until IDLE, then req1 granted in the first IDLE cycle.
REQ-031 rst_n pulsed low at T+4 of a transaction -> out_valid never rises for it; all outputs at reset values; next req0 request completes normally with req0 winning contention.
REQ-032 a=b=8'hFF and a=8'h00, b=8'hFF -> out_data 8'h00 and 8'hFF respectively, verifying every bit position including MSB.

Source files
------------

// File: rtl/xor_arbiter.sv
// Two-requester front end sharing one bit-serial XOR unit.
// Round-robin grant in IDLE, WIDTH serial SHIFT cycles, result held in DONE until taken.
module xor_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             grant;
  logic             res_bit;

  // ptr_q remembers the last requester served; contention goes to the other one.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~ptr_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are additionally gated by rst_n so they stay low for the whole reset.
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;

  assign res_bit = a_q[0] ^ b_q[0];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          id_d    = grant;
          ptr_d   = grant;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = {res_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Visible outputs only change once the full result is assembled.
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_data_d = {res_bit, res_q[WIDTH-1:1]};
          out_id_d   = id_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      out_data_q <= '0;
      out_id_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule
